// File: rtl/seq_fixed_mul.sv
// seq_fixed_mul: signed fixed-point multiplier, result = (a*b) >> FRAC,
// computed by a multi-cycle shift-add datapath on operand magnitudes.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (in_a, in_b, in_round, in_sat)
//   out_valid/out_ready   result handshake (out_data, out_ovf)
//   in_round              1: round half away from zero, 0: truncate
//   in_sat                1: saturate on overflow, 0: wrap
//   out_ovf               true result outside the signed WIDTH-bit range
module seq_fixed_mul #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_round,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [AW-1:0]    RND  = AW'(1) << (FRAC - 1);
    localparam logic [AW-1:0]    LIM  = AW'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [AW-1:0]    acc_q,   acc_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             sign_q,  sign_d;
    logic             round_q, round_d;
    logic             sat_q,   sat_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             ovf_q,   ovf_d;

    logic [AW-1:0]    acc_step;
    logic [AW-1:0]    m_c;
    logic [AW-1:0]    q_c;
    logic             ovf_c;
    logic [WIDTH-1:0] res_c;

    // UNROLL multiplier bits per cycle, LSB first; bit index = cnt*UNROLL+i.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (((mag_b_q >> (int'(cnt_q) * UNROLL + i)) & WIDTH'(1)) != '0)
                acc_step = acc_step
                    + ({{WIDTH{1'b0}}, mag_a_q} << (int'(cnt_q) * UNROLL + i));
        end
    end

    // Rounding on the magnitude gives half-away-from-zero after the sign
    // is reapplied; the negative range admits one extra magnitude step.
    always_comb begin
        m_c   = acc_q + (round_q ? RND : '0);
        q_c   = m_c >> FRAC;
        ovf_c = sign_q ? (q_c > LIM) : (q_c > (LIM - AW'(1)));
        if (sat_q && ovf_c)
            res_c = sign_q ? SMIN : SMAX;
        else
            res_c = sign_q ? (-q_c[WIDTH-1:0]) : q_c[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        round_d = round_q;
        sat_d   = sat_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // -MIN wraps to 2^(WIDTH-1), which is the correct magnitude
                    mag_a_d = in_a[WIDTH-1] ? WIDTH'(-in_a) : in_a;
                    mag_b_d = in_b[WIDTH-1] ? WIDTH'(-in_b) : in_b;
                    sign_d  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                    round_d = in_round;
                    sat_d   = in_sat;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = S_FIN;
            end
            S_FIN: begin
                data_d  = res_c;
                ovf_d   = ovf_c;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            round_q <= 1'b0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            round_q <= round_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_fixed_mul.sv
// tb_seq_fixed_mul: directed and random checks of seq_fixed_mul at
// Q16.16/UNROLL=1 and at WIDTH=16, FRAC=8, UNROLL=4.
module tb_seq_fixed_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_iv, a_ir, a_r, a_s, a_ov, a_or, a_ovf;
    logic [31:0] a_a, a_b, a_d;
    logic        b_iv, b_ir, b_r, b_s, b_ov, b_or, b_ovf;
    logic [15:0] b_a, b_b, b_d;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb_a[$];
    logic [32:0] sb_b[$];

    seq_fixed_mul #(.WIDTH(32), .FRAC(16), .UNROLL(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir),
        .in_a(a_a), .in_b(a_b), .in_round(a_r), .in_sat(a_s),
        .out_valid(a_ov), .out_ready(a_or),
        .out_data(a_d), .out_ovf(a_ovf)
    );

    seq_fixed_mul #(.WIDTH(16), .FRAC(8), .UNROLL(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir),
        .in_a(b_a), .in_b(b_b), .in_round(b_r), .in_sat(b_s),
        .out_valid(b_ov), .out_ready(b_or),
        .out_data(b_d), .out_ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full signed product, magnitude round/truncate, then range.
    function automatic logic [32:0] model(input int w, input int f,
        input logic [31:0] a, input logic [31:0] b, input bit rnd, input bit sat);
        longint sa, sb, p, mag, r, hi, lo;
        bit ovf;
        logic [31:0] res;
        if (w == 16) begin
            sa = longint'($signed(a[15:0]));
            sb = longint'($signed(b[15:0]));
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        p   = sa * sb;
        mag = (p < 0) ? -p : p;
        if (rnd) mag = mag + (longint'(1) << (f - 1));
        mag = mag >> f;
        r   = (p < 0) ? -mag : mag;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -hi - 1;
        ovf = (r > hi) || (r < lo);
        if (sat && ovf) r = (r > hi) ? hi : lo;
        res = r[31:0];
        if (w == 16) res = {16'h0, r[15:0]};
        return {ovf, res};
    endfunction

    task automatic op_a(input logic [31:0] a, input logic [31:0] b,
        input bit rnd, input bit sat, input logic [32:0] exp,
        input bit chk_lat, input bit hold);
        int k;
        logic [32:0] e;
        k = 0;
        while (!a_ir && k < 200) begin @(negedge clk); k++; end
        check("a_ready_wait", 64'(k < 200), 64'(1));
        a_a = a; a_b = b; a_r = rnd; a_s = sat; a_iv = 1'b1;
        sb_a.push_back(exp);
        @(negedge clk);
        a_iv = 1'b0; a_a = $urandom; a_b = $urandom;
        a_r = ~rnd; a_s = ~sat;
        k = 0;
        while (!a_ov && k < 200) begin @(negedge clk); k++; end
        if (chk_lat) check("a_latency", 64'(k), 64'(33));
        e = sb_a.pop_front();
        check("a_result", 64'({a_ovf, a_d}), 64'(e));
        if (!hold) begin
            a_or = 1'b1;
            @(negedge clk);
            a_or = 1'b0;
        end
    endtask

    task automatic op_b(input logic [15:0] a, input logic [15:0] b,
        input bit rnd, input bit sat, input logic [32:0] exp, input bit chk_lat);
        int k;
        logic [32:0] e;
        k = 0;
        while (!b_ir && k < 200) begin @(negedge clk); k++; end
        check("b_ready_wait", 64'(k < 200), 64'(1));
        b_a = a; b_b = b; b_r = rnd; b_s = sat; b_iv = 1'b1;
        sb_b.push_back(exp);
        @(negedge clk);
        b_iv = 1'b0; b_a = 16'($urandom); b_b = 16'($urandom);
        k = 0;
        while (!b_ov && k < 200) begin @(negedge clk); k++; end
        if (chk_lat) check("b_latency", 64'(k), 64'(5));
        e = sb_b.pop_front();
        check("b_result", 64'({b_ovf, 16'h0, b_d}), 64'(e));
        b_or = 1'b1;
        @(negedge clk);
        b_or = 1'b0;
    endtask

    initial begin : main
        logic [31:0] ra, rb;
        logic [31:0] held;
        rst  = 1'b1;
        a_iv = 1'b0; a_a = '0; a_b = '0; a_r = 1'b0; a_s = 1'b0; a_or = 1'b0;
        b_iv = 1'b0; b_a = '0; b_b = '0; b_r = 1'b0; b_s = 1'b0; b_or = 1'b0;
        #1;
        check("rst_in_ready", 64'(a_ir), 64'(1));
        check("rst_out_valid", 64'(a_ov), 64'(0));
        check("rst_out", 64'({a_ovf, a_d}), 64'(0));

        // in_valid during reset must not be taken
        a_iv = 1'b1; a_a = 32'h0001_0000; a_b = 32'h0001_0000;
        repeat (3) @(negedge clk);
        a_iv = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        check("rst_valid_ignored", 64'(a_ir), 64'(1));

        op_a(32'h0001_8000, 32'h0002_0000, 0, 0, {1'b0, 32'h0003_0000}, 1, 0);
        op_a(32'hFFFE_8000, 32'h0002_0000, 0, 0, {1'b0, 32'hFFFD_0000}, 1, 0);
        op_a(32'h0000_0001, 32'h0000_8000, 0, 0, {1'b0, 32'h0000_0000}, 0, 0);
        op_a(32'h0000_0001, 32'h0000_8000, 1, 0, {1'b0, 32'h0000_0001}, 0, 0);
        op_a(32'hFFFF_FFFF, 32'h0000_8000, 0, 0, {1'b0, 32'h0000_0000}, 0, 0);
        op_a(32'hFFFF_FFFF, 32'h0000_8000, 1, 0, {1'b0, 32'hFFFF_FFFF}, 0, 0);
        op_a(32'h7FFF_0000, 32'h0002_0000, 0, 1, {1'b1, 32'h7FFF_FFFF}, 0, 0);
        op_a(32'h7FFF_0000, 32'h0002_0000, 0, 0, {1'b1, 32'hFFFE_0000}, 0, 0);
        op_a(32'h8000_0000, 32'h8000_0000, 0, 1, {1'b1, 32'h7FFF_FFFF}, 0, 0);
        op_a(32'h0000_0000, 32'h1234_5678, 1, 1, {1'b0, 32'h0000_0000}, 1, 0);

        // backpressure: hold DONE for 10 cycles with a competing in_valid
        op_a(32'h0002_0000, 32'hFFFF_0000, 0, 0, {1'b0, 32'hFFFE_0000}, 0, 1);
        held = a_d;
        for (int i = 0; i < 10; i++) begin
            a_iv = 1'b1; a_a = 32'h0005_0000; a_b = 32'h0005_0000;
            @(negedge clk);
            check("bp_data", 64'(a_d), 64'(held));
            check("bp_state", 64'({a_ov, a_ir}), 64'(2'b10));
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        @(negedge clk);
        a_or = 1'b0;
        check("bp_release", 64'({a_ov, a_ir}), 64'(2'b01));
        op_a(32'h0003_0000, 32'h0000_4000, 0, 0, {1'b0, 32'h0000_C000}, 1, 0);

        // asynchronous reset in the middle of CALC
        a_a = 32'h0001_0000; a_b = 32'h0002_0000; a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_calc_busy", 64'(a_ir), 64'(0));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(a_ir), 64'(1));
        check("mid_rst_valid", 64'(a_ov), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        op_a(32'h0001_0000, 32'h0001_0000, 0, 0, {1'b0, 32'h0001_0000}, 1, 0);

        // random back-to-back, all four mode combinations
        for (int m = 0; m < 4; m++) begin
            for (int j = 0; j < 6; j++) begin
                ra = $urandom; rb = $urandom;
                if (j % 2 == 1) ra = $signed(ra) >>> 12;
                if (j >= 2)     rb = $signed(rb) >>> 10;
                op_a(ra, rb, m[0], m[1], model(32, 16, ra, rb, m[0], m[1]), 0, 0);
            end
        end

        op_b(16'h0180, 16'h0200, 0, 0, {1'b0, 32'h0000_0300}, 1);
        op_b(16'h8000, 16'h8000, 0, 1, {1'b1, 32'h0000_7FFF}, 1);
        for (int m = 0; m < 4; m++) begin
            for (int j = 0; j < 6; j++) begin
                ra = $urandom; rb = $urandom;
                if (j % 2 == 1) ra = {{16{1'b0}}, 16'($signed(ra[15:0]) >>> 6)};
                op_b(ra[15:0], rb[15:0], m[0], m[1],
                     model(16, 8, ra, rb, m[0], m[1]), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_fixed_mul.md
# seq_fixed_mul

Parametrised, signed fixed-point multiplier that computes `a*b >> FRAC` with a multi-cycle shift-add datapath. It carries valid/ready handshakes on input and output, and supports per-transaction round/truncate and saturate/wrap modes. It is the sequential, area-lean successor to the combinational Q16.16 multiplier. It sits between the DCT coefficient source and the accumulate stage.

## Interface
- `WIDTH`, 32: operand/result width, two's complement; even, ≥4.
- `FRAC`, 16: fractional bits; 1 ≤ FRAC ≤ WIDTH-1.
- `UNROLL`, 1: multiplier bits consumed per cycle; must divide WIDTH. N = WIDTH/UNROLL.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand word valid.
- `in_ready` out 1: block can accept an operand word.
- `in_a`, `in_b` in WIDTH each: signed fixed-point operands.
- `in_round` in 1: 1 = round half away from zero; 0 = truncate toward zero.
- `in_sat` in 1: 1 = saturate on overflow; 0 = wrap (low WIDTH bits of the signed shifted product).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out WIDTH: signed result.
- `out_ovf` out 1: true result was outside the WIDTH-bit signed range, in either mode.

## Operation
- States: IDLE, CALC, FIN, DONE. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch |a| and |b| as WIDTH-bit unsigned magnitudes (|−2^(WIDTH-1)| = 2^(WIDTH-1) fits). Also latch sign = a[MSB]^b[MSB], round and sat. Clear the 2·WIDTH-bit accumulator and the counter. Go to CALC.
- CALC:
  - Each cycle, for each of UNROLL multiplier bits i (LSB first), add |a|<<(bit index) when the bit is set.
  - Counter runs 0..N-1; on N-1 go to FIN.
- FIN computes the result in one cycle:
  - m = acc + (round ? 2^(FRAC-1) : 0); q = m >> FRAC, unsigned magnitude.
  - ovf = sign ? (q > 2^(WIDTH-1)) : (q > 2^(WIDTH-1)-1).
  - If sat and ovf: result = sign ? 0x80..0 : 0x7F..F.
  - Otherwise: result = low WIDTH bits of (sign ? −q : q).
  - Register `out_data` and `out_ovf`; go to DONE.
- DONE:
  - `out_valid`=1; `out_data`/`out_ovf` held stable.
  - On `out_ready`: go to IDLE.
- A zero operand still takes the full N cycles; there is no early exit.
- With round=0, sat=0, WIDTH=32, FRAC=16, the result is bit-identical to the legacy combinational multiplier.
- Inputs are ignored outside IDLE. `in_a`/`in_b`/mode bits may change freely after acceptance.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, accumulator/counter 0.
- Accepting edge E0. CALC occupies edges E1..EN, FIN is edge EN+1, and `out_valid` is high from just after EN+1. Latency is N+1 cycles, which is 33 at defaults.
- `in_ready` is low from E0 until the edge after the output handshake. Initiation interval = N+3 cycles minimum (accept, N calc, fin, done handshake, idle).
- `in_ready` and `out_valid` are never high together. `in_ready` is a pure decode of state IDLE, with no combinational path from `out_ready`.
- Backpressure: DONE persists indefinitely while `out_ready`=0, with outputs unchanged.
- `rst` asserted in any state, mid-CALC included: outputs go to reset values immediately (async). The in-flight operation is discarded with no partial result. Operation resumes from IDLE on the first edge after deassertion.
- `in_valid` asserted during reset: not accepted.

## Test plan
All values are defaults (Q16.16, UNROLL=1) unless stated.
- 0x00018000×0x00020000, round=0, sat=0 → `out_data`=0x00030000, `out_ovf`=0; `out_valid` rises 33 cycles after accept.
- 0xFFFE8000×0x00020000 → 0xFFFD0000, ovf=0. 0x00000001×0x00008000 → 0x00000000 (trunc) / 0x00000001 (round). 0xFFFFFFFF×0x00008000 → 0x00000000 (trunc) / 0xFFFFFFFF (round).
- 0x7FFF0000×0x00020000: sat=1 → 0x7FFFFFFF, ovf=1; sat=0 → 0xFFFE0000, ovf=1. 0x80000000×0x80000000, sat=1 → 0x7FFFFFFF, ovf=1.
- Hold `out_ready`=0 for 10 cycles after `out_valid`: output stable, `in_ready`=0, and a new `in_valid` is ignored. After release, `in_ready` returns on the next cycle and the second operation completes correctly.
- Assert `rst` at CALC cycle 12: `out_valid`=0 and `in_ready`=1 immediately. The next transaction 0x00010000×0x00010000 → 0x00010000.
- UNROLL=4, WIDTH=16, FRAC=8: 0x0180×0x0200 → 0x0300 with latency 5. Random back-to-back regression against a reference model for all four mode combinations.
